reaction_round_arbiter: RTL and testbench



---
 rtl/reaction_round_arbiter_pkg.sv | 24 ++
 rtl/reaction_round_arbiter_lfsr16.sv | 19 +
 rtl/reaction_round_arbiter.sv | 118 +++++++++++
 tb/tb_reaction_round_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_round_arbiter_pkg.sv
// Shared definitions for the reaction round arbiter: state encoding, winner codes
// and the LFSR feedback polynomial.
package reaction_round_arbiter_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ARM    = 2'd1;
   localparam logic [1:0] GO     = 2'd2;
   localparam logic [1:0] RESULT = 2'd3;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_A    = 2'b01,
      WIN_B    = 2'b10,
      WIN_TIE  = 2'b11
   } winner_t;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/reaction_round_arbiter_lfsr16.sv
// Free-running 16-bit Galois LFSR; supplies the random part of the ARM delay.
module lfsr16
   import reaction_round_arbiter_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] state
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= SEED;
      else
         state <= lfsrNext(state);
   end

endmodule

// File: rtl/reaction_round_arbiter.sv
// Sequences one reaction round: random ARM wait, GO window, then a held RESULT
// with single-clock point pulses, false-start flags and a winner code.
module reaction_round_arbiter
   import reaction_round_arbiter_pkg::*;
#(
   parameter int          DELAY_MIN_MS    = 500,
   parameter int          DELAY_SPAN_BITS = 10,
   parameter int          WINDOW_MS       = 1000,
   parameter int          HOLD_MS         = 2000,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       press_a,
   input  logic       press_b,
   input  logic       game_over,
   output logic       led_wait,
   output logic       led_go,
   output logic       point_a,
   output logic       point_b,
   output logic [1:0] foul,
   output logic [1:0] winner,
   output logic       busy
);

   localparam logic [15:0] SPAN_MASK = 16'((32'd1 << DELAY_SPAN_BITS) - 32'd1);

   logic [1:0]  state;
   logic [15:0] cnt;
   logic [15:0] lfsr;
   logic [15:0] armLoad;
   logic        expire;

   lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
      .clock (clock),
      .reset (reset),
      .state (lfsr)
   );

   assign armLoad = 16'(DELAY_MIN_MS) + (lfsr & SPAN_MASK);
   assign expire  = tick && (cnt == 16'd1);

   // Round FSM. Phase loads override the tick decrement, so each phase lasts
   // exactly its load value in ticks; presses take priority over expiry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 16'd0;
         led_wait <= 1'b0;
         led_go   <= 1'b0;
         point_a  <= 1'b0;
         point_b  <= 1'b0;
         foul     <= 2'b00;
         winner   <= WIN_NONE;
         busy     <= 1'b0;
      end else begin
         point_a <= 1'b0;
         point_b <= 1'b0;
         if (tick && cnt != 16'd0)
            cnt <= cnt - 16'd1;

         case (state)
            IDLE: begin
               if (start && !game_over) begin
                  state    <= ARM;
                  cnt      <= armLoad;
                  foul     <= 2'b00;
                  winner   <= WIN_NONE;
                  led_wait <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ARM: begin
               if (press_a || press_b) begin
                  state    <= RESULT;
                  cnt      <= 16'(HOLD_MS);
                  led_wait <= 1'b0;
                  foul     <= {press_b, press_a};
                  point_a  <= press_b && !press_a;
                  point_b  <= press_a && !press_b;
                  if (press_a && press_b)
                     winner <= WIN_NONE;
                  else if (press_a)
                     winner <= WIN_B;
                  else
                     winner <= WIN_A;
               end else if (expire) begin
                  state    <= GO;
                  cnt      <= 16'(WINDOW_MS);
                  led_wait <= 1'b0;
                  led_go   <= 1'b1;
               end
            end
            GO: begin
               if (press_a || press_b || expire) begin
                  state   <= RESULT;
                  cnt     <= 16'(HOLD_MS);
                  led_go  <= 1'b0;
                  point_a <= press_a && !press_b;
                  point_b <= press_b && !press_a;
                  // {B,A} press bits line up with the winner codes, timeout included
                  winner  <= {press_b, press_a};
               end
            end
            RESULT: begin
               if (expire) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_round_arbiter.sv
// Scoreboard bench for reaction_round_arbiter: expected round outcomes are queued
// when a round is driven and compared when the monitor sees busy fall.
module tb_reaction_round_arbiter;
   import reaction_round_arbiter_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       press_a = 1'b0;
   logic       press_b = 1'b0;
   logic       game_over = 1'b0;
   logic       led_wait, led_go, point_a, point_b, busy;
   logic [1:0] foul, winner;

   reaction_round_arbiter #(
      .DELAY_MIN_MS    (4),
      .DELAY_SPAN_BITS (2),
      .WINDOW_MS       (5),
      .HOLD_MS         (3),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick),
      .start     (start),
      .press_a   (press_a),
      .press_b   (press_b),
      .game_over (game_over),
      .led_wait  (led_wait),
      .led_go    (led_go),
      .point_a   (point_a),
      .point_b   (point_b),
      .foul      (foul),
      .winner    (winner),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] winner;
      logic [1:0] foul;
      int         pa;
      int         pb;
      int         goSeen;
      int         armTicks;
      int         goTicks;
   } round_t;

   round_t      expQ[$];
   int          armLog[$];
   int          checks = 0;
   int          passes = 0;
   int          tickPhase = 0;
   logic [15:0] lfsrModel = 16'hACE1;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got == exp)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic void pushExp(input logic [1:0] w, input logic [1:0] f, input int pa,
                                   input int pb, input int go, input int arm, input int goT);
      round_t e;
      e.winner = w; e.foul = f; e.pa = pa; e.pb = pb;
      e.goSeen = go; e.armTicks = arm; e.goTicks = goT;
      expQ.push_back(e);
   endfunction

   // Reference LFSR: x^16+x^14+x^13+x^11+1, one step per clock, reseeded by reset
   initial forever begin
      @(posedge clock or posedge reset);
      if (reset)
         lfsrModel = 16'hACE1;
      else
         lfsrModel = {1'b0, lfsrModel[15:1]} ^ (lfsrModel[0] ? 16'hB400 : 16'h0000);
   end

   // One-clock tick every fourth clock, changed just after the rising edge
   initial forever begin
      @(posedge clock);
      #1;
      tick = (tickPhase == 3);
      tickPhase = (tickPhase + 1) % 4;
   end

   // Monitor: accumulates per-round observations and scores them when busy falls
   initial begin
      int   mArm, mGo, mRes, mPa, mPb, mGoSeen, mBothPts, mBothLeds;
      logic prevBusy;
      round_t e;
      mArm = 0; mGo = 0; mRes = 0; mPa = 0; mPb = 0;
      mGoSeen = 0; mBothPts = 0; mBothLeds = 0; prevBusy = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            mArm = 0; mGo = 0; mRes = 0; mPa = 0; mPb = 0;
            mGoSeen = 0; mBothPts = 0; mBothLeds = 0; prevBusy = 1'b0;
         end else begin
            if (led_wait && tick) mArm++;
            if (led_go) mGoSeen = 1;
            if (led_go && tick) mGo++;
            if (busy && !led_wait && !led_go && tick) mRes++;
            if (point_a) mPa++;
            if (point_b) mPb++;
            if (point_a && point_b) mBothPts = 1;
            if (led_wait && led_go) mBothLeds = 1;
            if (prevBusy && !busy) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedRound", 1, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("winner", int'(winner), int'(e.winner));
                  checkOutput("foul", int'(foul), int'(e.foul));
                  checkOutput("pointA", mPa, e.pa);
                  checkOutput("pointB", mPb, e.pb);
                  checkOutput("goSeen", mGoSeen, e.goSeen);
                  checkOutput("resultTicks", mRes, 3);
                  checkOutput("bothPoints", mBothPts, 0);
                  checkOutput("bothLeds", mBothLeds, 0);
                  if (e.armTicks >= 0) begin
                     checkOutput("armTicks", mArm, e.armTicks);
                     armLog.push_back(mArm);
                  end
                  if (e.goTicks >= 0) checkOutput("goTicks", mGo, e.goTicks);
               end
               mArm = 0; mGo = 0; mRes = 0; mPa = 0; mPb = 0;
               mGoSeen = 0; mBothPts = 0; mBothLeds = 0;
            end
            prevBusy = busy;
         end
      end
   end

   // Drive one clock of start/press inputs from the drive point (edge + 2)
   task automatic applyStimulus(input logic st, input logic a, input logic b);
      start = st; press_a = a; press_b = b;
      @(posedge clock); #2;
      start = 1'b0; press_a = 1'b0; press_b = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin @(posedge clock); #2; end
   endtask

   task automatic waitTicks(input int n);
      int k = 0;
      int guard = 0;
      while (k < n && guard < 500) begin
         if (tick) k++;
         @(posedge clock); #2;
         guard++;
      end
      if (k != n) checkOutput("waitTicksTimeout", k, n);
   endtask

   task automatic waitUntilTick();
      int guard = 0;
      while (!tick && guard < 8) begin
         @(posedge clock); #2;
         guard++;
      end
      if (!tick) checkOutput("waitTickTimeout", 0, 1);
   endtask

   // which: 0 = led_go high, 1 = busy low
   task automatic waitFor(input int which, input string tag);
      int guard = 0;
      logic met;
      met = (which == 0) ? led_go : !busy;
      while (!met && guard < 300) begin
         @(posedge clock); #2;
         guard++;
         met = (which == 0) ? led_go : !busy;
      end
      if (!met) checkOutput(tag, 0, 1);
   endtask

   task automatic startRound(output int armLen);
      armLen = 4 + int'(lfsrModel[1:0]);
      applyStimulus(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      int minV, maxV, distinct;
      bit seen[int];

      @(posedge clock); #2;
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetLeds", int'({led_wait, led_go}), 0);
      checkOutput("resetWinnerFoul", int'({winner, foul}), 0);
      checkOutput("resetPoints", int'({point_a, point_b}), 0);
      idleCycles(2);
      reset = 1'b0;
      idleCycles(2);

      // Normal A win two ticks into GO
      startRound(len);
      pushExp(WIN_A, 2'b00, 1, 0, 1, len, -1);
      waitFor(0, "goTimeout");
      waitTicks(2);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // False start by B one tick into ARM
      startRound(len);
      pushExp(WIN_A, 2'b10, 1, 0, 0, -1, -1);
      waitTicks(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // Tie in GO
      startRound(len);
      pushExp(WIN_TIE, 2'b00, 0, 0, 1, len, -1);
      waitFor(0, "goTimeout");
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // Simultaneous false start
      startRound(len);
      pushExp(WIN_NONE, 2'b11, 0, 0, 0, -1, -1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // Timeout: GO lasts the full window
      startRound(len);
      pushExp(WIN_NONE, 2'b00, 0, 0, 1, len, 5);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // press_a on the GO expiry clock beats the timeout
      startRound(len);
      pushExp(WIN_A, 2'b00, 1, 0, 1, len, 5);
      waitFor(0, "goTimeout");
      waitTicks(4);
      waitUntilTick();
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // press_a on the ARM expiry clock is a false start
      startRound(len);
      pushExp(WIN_B, 2'b01, 0, 1, 0, -1, -1);
      waitTicks(len - 1);
      waitUntilTick();
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // start blocked by game_over
      game_over = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(3);
      checkOutput("gameOverBusy", int'(busy), 0);
      checkOutput("gameOverLedWait", int'(led_wait), 0);
      game_over = 1'b0;
      idleCycles(1);

      // start during GO is ignored and not queued
      startRound(len);
      pushExp(WIN_NONE, 2'b00, 0, 0, 1, len, 5);
      waitFor(0, "goTimeout");
      waitTicks(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("startInGoLedGo", int'(led_go), 1);
      checkOutput("startInGoBusy", int'(busy), 1);
      waitFor(1, "idleTimeout");
      idleCycles(4);
      checkOutput("noQueuedStart", int'(busy), 0);

      // Reset in GO aborts asynchronously with no point pulse
      startRound(len);
      waitFor(0, "goTimeout");
      idleCycles(1);
      #1 reset = 1'b1;
      #1;
      checkOutput("resetGoLed", int'(led_go), 0);
      checkOutput("resetGoBusy", int'(busy), 0);
      checkOutput("resetGoPoints", int'({point_a, point_b}), 0);
      @(posedge clock); #2;
      reset = 1'b0;
      idleCycles(2);

      startRound(len);
      pushExp(WIN_B, 2'b00, 0, 1, 1, len, -1);
      waitFor(0, "goTimeout");
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitFor(1, "idleTimeout");
      idleCycles(1);

      // Random delay spread over 20 consecutive rounds
      armLog.delete();
      for (int i = 0; i < 20; i++) begin
         startRound(len);
         pushExp(WIN_A, 2'b00, 1, 0, 1, len, -1);
         waitFor(0, "goTimeout");
         applyStimulus(1'b0, 1'b1, 1'b0);
         waitFor(1, "idleTimeout");
         idleCycles(1 + (i % 3));
      end
      minV = 1000; maxV = -1; distinct = 0;
      foreach (armLog[i]) begin
         if (armLog[i] < minV) minV = armLog[i];
         if (armLog[i] > maxV) maxV = armLog[i];
         if (!seen.exists(armLog[i])) begin
            seen[armLog[i]] = 1'b1;
            distinct++;
         end
      end
      checkOutput("randomRounds", armLog.size(), 20);
      checkOutput("armMinInRange", int'(minV >= 4), 1);
      checkOutput("armMaxInRange", int'(maxV <= 7), 1);
      checkOutput("armDistinct", int'(distinct >= 2), 1);

      checkOutput("scoreboardEmpty", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
